// File: rtl/ip_drr_sched.sv
// Deficit-round-robin gate in front of ip_arb_mux: one source at a time, byte-fair.
// Optional payload watchdog enabled by defining IP_DRR_SCHED_TIMEOUT_EN.
module ip_drr_sched #(
    parameter int S_COUNT       = 4,
    parameter int DEFICIT_WIDTH = 18,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_COUNT-1:0]     req_hdr_valid,
    output logic [S_COUNT-1:0]     req_hdr_ready,
    input  logic [S_COUNT*16-1:0]  req_ip_length,
    output logic [S_COUNT-1:0]     gate_hdr_valid,
    input  logic [S_COUNT-1:0]     gate_hdr_ready,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    input  logic [S_COUNT*16-1:0]  quantum,
    output logic [S_COUNT-1:0]     grant,
    output logic                   busy,
    output logic                   timeout
);

    localparam int          PTR_W     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int unsigned S_COUNT_U = S_COUNT;

    if (S_COUNT < 2 || S_COUNT > 16) begin : g_bad_s_count
        $error("ip_drr_sched: S_COUNT must be in 2..16");
    end
    if (DEFICIT_WIDTH < 17) begin : g_bad_deficit_width
        $error("ip_drr_sched: DEFICIT_WIDTH must be at least 17");
    end
    if (TIMEOUT_WIDTH < 1) begin : g_bad_timeout_width
        $error("ip_drr_sched: TIMEOUT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FRAME
    } state_t;

    state_t                   state_q, state_d;
    logic [S_COUNT-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         gidx_q, gidx_d;
    logic [DEFICIT_WIDTH-1:0] deficit_q [S_COUNT];
    logic [DEFICIT_WIDTH-1:0] deficit_d [S_COUNT];

    logic [DEFICIT_WIDTH-1:0] len_ext   [S_COUNT];
    logic [DEFICIT_WIDTH-1:0] repl_val  [S_COUNT];
    logic [S_COUNT-1:0]       eligible;
    logic                     found;
    logic [PTR_W-1:0]         sel_idx;
    logic [PTR_W:0]           ptr_inc;
    logic [PTR_W-1:0]         ptr_wrap;
    logic                     beat;
    logic                     frame_done;
    logic                     in_grant;

`ifdef IP_DRR_SCHED_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                     timeout_q, timeout_d;
`endif

    // Eligibility and the saturating replenish value for every source.
    always_comb begin
        for (int unsigned i = 0; i < S_COUNT_U; i++) begin
            logic [DEFICIT_WIDTH:0] sum;
            len_ext[i]  = {{(DEFICIT_WIDTH-16){1'b0}}, req_ip_length[16*i +: 16]};
            eligible[i] = req_hdr_valid[i] && (deficit_q[i] >= len_ext[i]);
            sum = {1'b0, deficit_q[i]}
                + {{(DEFICIT_WIDTH-15){1'b0}}, quantum[16*i +: 16]};
            repl_val[i] = sum[DEFICIT_WIDTH] ? '1 : sum[DEFICIT_WIDTH-1:0];
        end
    end

    // First eligible source at or after the pointer, wrapping around.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned k = 0; k < S_COUNT_U; k++) begin
            int unsigned idx;
            idx = 32'(ptr_q) + k;
            if (idx >= S_COUNT_U) begin
                idx = idx - S_COUNT_U;
            end
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                sel_idx = PTR_W'(idx);
            end
        end
    end

    assign ptr_inc  = {1'b0, gidx_q} + (PTR_W+1)'(1);
    assign ptr_wrap = (ptr_inc == (PTR_W+1)'(S_COUNT)) ? '0 : ptr_inc[PTR_W-1:0];
    assign beat     = mon_tvalid & mon_tready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        deficit_d  = deficit_q;
        frame_done = 1'b0;
`ifdef IP_DRR_SCHED_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    state_d          = ST_GRANT;
                end else if (|req_hdr_valid) begin
                    // Idle sources lose their credit; requesters accumulate.
                    for (int unsigned i = 0; i < S_COUNT_U; i++) begin
                        deficit_d[i] = req_hdr_valid[i] ? repl_val[i] : '0;
                    end
                end
            end
            ST_GRANT: begin
                if (!req_hdr_valid[gidx_q]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (gate_hdr_ready[gidx_q]) begin
                    deficit_d[gidx_q] = deficit_q[gidx_q] - len_ext[gidx_q];
                    state_d           = ST_FRAME;
`ifdef IP_DRR_SCHED_TIMEOUT_EN
                    tcnt_d            = '0;
`endif
                end
            end
            ST_FRAME: begin
                if (beat && mon_tlast) begin
                    frame_done = 1'b1;
`ifdef IP_DRR_SCHED_TIMEOUT_EN
                end else if (beat) begin
                    tcnt_d = '0;
                end else if (&tcnt_q) begin
                    timeout_d  = 1'b1;
                    frame_done = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
`endif
                end
                if (frame_done) begin
                    grant_d = '0;
                    ptr_d   = ptr_wrap;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            for (int unsigned i = 0; i < S_COUNT_U; i++) begin
                deficit_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            deficit_q <= deficit_d;
        end
    end

`ifdef IP_DRR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign in_grant       = (state_q == ST_GRANT);
    assign gate_hdr_valid = grant_q & req_hdr_valid & {S_COUNT{in_grant}};
    assign req_hdr_ready  = grant_q & gate_hdr_ready & {S_COUNT{in_grant}};
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
